pll_reset_sequencer: RTL and testbench

- Sequences reset for the computer from the system PLL's lock status.
- Drives the PLL reset, waits for a stable lock, then releases the peripheral reset and, after a delay, the CPU reset.
- Any lock loss re-asserts reset; any external request restarts the whole sequence.
- Runs on the free-running 50 MHz board clock, which is the PLL refclk, never on a PLL output, because PLL outputs are invalid while unlocked.

---
 rtl/pll_rst_pkg.sv | 24 ++
 rtl/bit_synchronizer.sv | 24 ++
 rtl/pll_reset_sequencer.sv | 147 ++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pll_rst_pkg.sv
// pll_rst_pkg: shared types and default constants for the PLL reset sequencer.
//   state_e        - sequencer state, encoding is exposed on the debug LEDs
//   DEF_*          - default parameter values for pll_reset_sequencer
//   LOCK_LOSS_MAX  - saturation value of the lock-loss counter
package pll_rst_pkg;

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_PERIPH    = 3'd3,
        ST_RUN       = 3'd4
    } state_e;

    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_PLL_RST_CYCLES = 16;
    localparam int DEF_LOCK_TIMEOUT   = 50000;  // 1 ms at 50 MHz
    localparam int DEF_STABLE_CYCLES  = 1024;
    localparam int DEF_CPU_DELAY      = 64;
    localparam int DEF_CNT_W          = 16;

    localparam logic [7:0] LOCK_LOSS_MAX = 8'd255;

endpackage

// File: rtl/bit_synchronizer.sv
// bit_synchronizer: multi-flop synchronizer for a single asynchronous bit.
//   clk   - destination clock
//   rst_n - synchronous active-low reset, clears every stage to 0
//   d     - asynchronous input
//   q     - synchronized output, STAGES edges behind d
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[STAGES-2:0], d};
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: drives the PLL reset, waits for a stable lock, then
// releases the peripheral reset and, after a delay, the CPU reset. Runs on the
// board clock (PLL refclk) because PLL outputs are not valid while unlocked.
//   clk              - 50 MHz board clock
//   rst_n            - synchronous active-low reset
//   pll_locked_async - PLL locked flag, asynchronous to clk
//   ext_rst_req      - synchronous full-restart request
//   pll_rst          - PLL reset, active-high
//   periph_rst_n     - peripheral/memory reset, active-low
//   cpu_rst_n        - CPU reset, active-low
//   sys_ready        - high only in RUN
//   lock_loss_cnt    - saturating count of lock losses after release
//   state_o          - current state, for debug LEDs
module pll_reset_sequencer
    import pll_rst_pkg::*;
#(
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int CPU_DELAY      = DEF_CPU_DELAY,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked_async,
    input  logic       ext_rst_req,
    output logic       pll_rst,
    output logic       periph_rst_n,
    output logic       cpu_rst_n,
    output logic       sys_ready,
    output logic [7:0] lock_loss_cnt,
    output logic [2:0] state_o
);

    logic             locked_s;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       lock_loss_q, lock_loss_d;
    logic             pll_rst_q, pll_rst_d;
    logic             periph_rst_n_q, periph_rst_n_d;
    logic             cpu_rst_n_q, cpu_rst_n_d;
    logic             sys_ready_q, sys_ready_d;

    bit_synchronizer #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked_async),
        .q     (locked_s)
    );

    // State, counter and outputs share one register process; outputs are
    // decoded from next-state so they move on the same edge as the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_PLL_RST;
            cnt_q          <= '0;
            lock_loss_q    <= '0;
            pll_rst_q      <= 1'b1;
            periph_rst_n_q <= 1'b0;
            cpu_rst_n_q    <= 1'b0;
            sys_ready_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            lock_loss_q    <= lock_loss_d;
            pll_rst_q      <= pll_rst_d;
            periph_rst_n_q <= periph_rst_n_d;
            cpu_rst_n_q    <= cpu_rst_n_d;
            sys_ready_q    <= sys_ready_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        lock_loss_d = lock_loss_q;
        if (ext_rst_req) begin
            // Held request parks in PLL_RST with the counter pinned at 0.
            state_d = ST_PLL_RST;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_PLL_RST: begin
                    if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        state_d = ST_PLL_RST;
                        cnt_d   = '0;
                    end
                end
                ST_STABLE: begin
                    // Pre-release drop is not counted as a lock loss.
                    if (!locked_s) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                        state_d = ST_PERIPH;
                        cnt_d   = '0;
                    end
                end
                ST_PERIPH, ST_RUN: begin
                    if (!locked_s) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                        if (lock_loss_q != LOCK_LOSS_MAX)
                            lock_loss_d = lock_loss_q + 8'd1;
                    end else if (state_q == ST_RUN) begin
                        cnt_d = '0;
                    end else if (cnt_q == CNT_W'(CPU_DELAY - 1)) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_PLL_RST;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        pll_rst_d      = (state_d == ST_PLL_RST);
        periph_rst_n_d = (state_d == ST_PERIPH) || (state_d == ST_RUN);
        cpu_rst_n_d    = (state_d == ST_RUN);
        sys_ready_d    = (state_d == ST_RUN);
    end

    assign pll_rst       = pll_rst_q;
    assign periph_rst_n  = periph_rst_n_q;
    assign cpu_rst_n     = cpu_rst_n_q;
    assign sys_ready     = sys_ready_q;
    assign lock_loss_cnt = lock_loss_q;
    assign state_o       = state_q;

    // The CPU must never run out of reset while peripherals are held.
    a_cpu_after_periph: assert property (@(posedge clk) cpu_rst_n_q |-> periph_rst_n_q);

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: directed timing checks plus randomized lock/request
// traffic compared cycle-by-cycle against a phase/duration reference model.
module tb_pll_reset_sequencer;

    localparam int SYNC = 2;
    localparam int PRC  = 4;
    localparam int LTO  = 100;
    localparam int STC  = 16;
    localparam int CPD  = 8;
    localparam int CW   = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked_async = 1'b0;
    logic       ext_rst_req = 1'b0;
    logic       pll_rst, periph_rst_n, cpu_rst_n, sys_ready;
    logic [7:0] lock_loss_cnt;
    logic [2:0] state_o;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    pll_reset_sequencer #(
        .SYNC_STAGES    (SYNC),
        .PLL_RST_CYCLES (PRC),
        .LOCK_TIMEOUT   (LTO),
        .STABLE_CYCLES  (STC),
        .CPU_DELAY      (CPD),
        .CNT_W          (CW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pll_locked_async (pll_locked_async),
        .ext_rst_req      (ext_rst_req),
        .pll_rst          (pll_rst),
        .periph_rst_n     (periph_rst_n),
        .cpu_rst_n        (cpu_rst_n),
        .sys_ready        (sys_ready),
        .lock_loss_cnt    (lock_loss_cnt),
        .state_o          (state_o)
    );

    // Reference model: phase number, time spent in phase, loss count, and
    // a queue delaying the async lock by the synchronizer depth.
    // Phases: 0 pll reset, 1 wait lock, 2 stable, 3 periph, 4 run.
    int m_ph = 0;
    int m_t = 0;
    int m_loss = 0;
    int lq[$];
    int dur[4] = '{PRC, LTO, STC, CPD};   // length of each timed phase
    int nxt[4] = '{1, 0, 3, 4};           // phase reached when it expires

    task automatic chk(string tag, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_step();
        int ls;
        if (!rst_n) begin
            m_ph = 0; m_t = 0; m_loss = 0;
            lq.delete();
            repeat (SYNC) lq.push_back(0);
            return;
        end
        ls = lq.pop_front();
        lq.push_back(int'(pll_locked_async));
        if (ext_rst_req) begin
            m_ph = 0; m_t = 0;
        end else if (ls == 0 && m_ph >= 3) begin
            m_ph = 1; m_t = 0;
            if (m_loss < 255) m_loss++;
        end else if (ls == 0 && m_ph == 2) begin
            m_ph = 1; m_t = 0;
        end else if (ls == 1 && m_ph == 1) begin
            m_ph = 2; m_t = 0;
        end else if (m_ph < 4 && m_t + 1 == dur[m_ph]) begin
            m_ph = nxt[m_ph]; m_t = 0;
        end else begin
            m_t++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("state",         int'(state_o),       m_ph);
        chk("pll_rst",       int'(pll_rst),       int'(m_ph == 0));
        chk("periph_rst_n",  int'(periph_rst_n),  int'(m_ph >= 3));
        chk("cpu_rst_n",     int'(cpu_rst_n),     int'(m_ph == 4));
        chk("sys_ready",     int'(sys_ready),     int'(m_ph == 4));
        chk("lock_loss_cnt", int'(lock_loss_cnt), m_loss);
    endtask

    task automatic wait_ready(string tag);
        int k = 0;
        while (!sys_ready && k < 500) begin tick(); k++; end
        chk(tag, int'(sys_ready), 1);
    endtask

    task automatic wait_drop();
        int k = 0;
        while (sys_ready && k < 10) begin tick(); k++; end
    endtask

    int n;
    int hi;
    logic prev;
    int rises[$];
    int r;

    initial begin
        // Power-up
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_pll_rst", int'(pll_rst), 1);
        chk("rst_loss", int'(lock_loss_cnt), 0);
        rst_n = 1'b1;
        n = 0;
        while (pll_rst && n < 50) begin tick(); n++; end
        chk("pwrup_pll_rst_len", n, PRC);
        repeat (10) tick();
        pll_locked_async = 1'b1;
        n = 0;
        while (!periph_rst_n && n < 200) begin tick(); n++; end
        chk("pwrup_periph_lat", n, SYNC + STC + 1);
        n = 0;
        while (!cpu_rst_n && n < 100) begin tick(); n++; end
        chk("pwrup_cpu_lat", n, CPD);
        chk("pwrup_ready", int'(sys_ready), 1);
        chk("pwrup_loss", int'(lock_loss_cnt), 0);

        // Lock never asserts: periodic PLL reset pulses
        pll_locked_async = 1'b0;
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        hi = 0; prev = 1'b1;
        for (int i = 0; i < 320; i++) begin
            tick();
            if (pll_rst && !prev) rises.push_back(i);
            hi += int'(pll_rst);
            prev = pll_rst;
        end
        chk("nolock_rises", rises.size(), 3);
        if (rises.size() >= 2) chk("nolock_period", rises[1] - rises[0], LTO + PRC);
        chk("nolock_hi_cycles", hi, (PRC - 1) + 3 * PRC);

        // One-cycle lock drop in RUN
        pll_locked_async = 1'b1;
        wait_ready("run1_ready");
        pll_locked_async = 1'b0; tick(); pll_locked_async = 1'b1;
        n = 0;
        while (sys_ready && n < 10) begin tick(); n++; end
        chk("drop_lat", n, SYNC);
        chk("drop_cpu", int'(cpu_rst_n), 0);
        chk("drop_periph", int'(periph_rst_n), 0);
        chk("drop_loss", int'(lock_loss_cnt), 1);
        n = 0;
        while (!periph_rst_n && n < 100) begin tick(); n++; end
        chk("relock_periph_lat", n, STC + 1);
        n = 0;
        while (!cpu_rst_n && n < 100) begin tick(); n++; end
        chk("relock_cpu_lat", n, CPD);

        // Glitch in STABLE at cnt = 10
        ext_rst_req = 1'b1; tick(); ext_rst_req = 1'b0;
        n = 0;
        while (state_o != 3'd2 && n < 100) begin tick(); n++; end
        chk("reach_stable", int'(state_o), 2);
        repeat (8) tick();
        pll_locked_async = 1'b0; tick(); pll_locked_async = 1'b1;
        n = 9;
        while (!periph_rst_n && n < 200) begin tick(); n++; end
        chk("glitch_periph_lat", n, 12 + STC);
        chk("glitch_loss", int'(lock_loss_cnt), 1);
        wait_ready("glitch_ready");

        // ext_rst_req pulse in RUN
        ext_rst_req = 1'b1; tick(); ext_rst_req = 1'b0;
        chk("ext_state", int'(state_o), 0);
        chk("ext_loss", int'(lock_loss_cnt), 1);
        n = 0;
        while (pll_rst && n < 50) begin tick(); n++; end
        chk("ext_pll_rst_len", n, PRC);
        wait_ready("ext_ready");

        // ext_rst_req together with lock loss takes the restart path
        pll_locked_async = 1'b0; tick(); tick();
        ext_rst_req = 1'b1; tick(); ext_rst_req = 1'b0;
        chk("extloss_state", int'(state_o), 0);
        chk("extloss_loss", int'(lock_loss_cnt), 1);
        pll_locked_async = 1'b1;
        wait_ready("extloss_ready");

        // 300 lock losses: counter saturates
        for (int k = 0; k < 300; k++) begin
            pll_locked_async = 1'b0; tick(); pll_locked_async = 1'b1;
            wait_drop();
            wait_ready("sat_ready");
        end
        chk("sat_loss", int'(lock_loss_cnt), 255);
        pll_locked_async = 1'b0; tick(); pll_locked_async = 1'b1;
        wait_drop();
        chk("sat_hold", int'(lock_loss_cnt), 255);

        // Randomized traffic: lock dropouts, restarts, mid-operation resets
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 99));
            pll_locked_async = (r >= 3);
            ext_rst_req = (r == 99) && ($urandom_range(0, 3) == 0);
            rst_n = !((r == 98) && ($urandom_range(0, 7) == 0));
            tick();
        end
        ext_rst_req = 1'b0;
        rst_n = 1'b0; tick();
        chk("final_rst_state", int'(state_o), 0);
        chk("final_rst_loss", int'(lock_loss_cnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
